// File: rtl/burst_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_initiator_pkg
// Description : Shared widths, FSM state, error codes and request record for
//               the burst initiator and its range checker.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_initiator_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int BURST_LEN  = 8;
    localparam int STRIDE_LEN = 4;
    localparam int LEN_WIDTH  = $clog2(BURST_LEN) + 1;
    localparam int IDX_WIDTH  = $clog2(BURST_LEN);
    localparam int ADDR_MAX   = (1 << ADDR_WIDTH) - 1;
    // Wide enough that addr + stride*(len-1) can never wrap.
    localparam int CHK_WIDTH  = ADDR_WIDTH + STRIDE_LEN + IDX_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } bt_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_LEN    = 2'd1,
        ERR_STRIDE = 2'd2,
        ERR_RANGE  = 2'd3
    } bt_err_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [STRIDE_LEN-1:0] stride;
        logic [LEN_WIDTH-1:0]  len;
    } burst_req_t;

endpackage
`default_nettype wire

// File: rtl/burst_range_check.sv
`default_nettype none
// ============================================================================
// Module      : burst_range_check
// Description : Combinational legality check of a burst request.
//               Priority: bad length > stride too large > end address out of
//               range. Reusable wherever a request record must be validated.
// Ports       : req  in  burst_req_t  request (addr, stride, len)
//               err  out bt_err_e     ERR_NONE when the request is legal
// Revision    : 1.0 - initial release
// ============================================================================
module burst_range_check
    import burst_initiator_pkg::*;
(
    input  burst_req_t req,
    output bt_err_e    err
);

    localparam logic [CHK_WIDTH-1:0] MAX_C = CHK_WIDTH'(ADDR_MAX);

    logic [LEN_WIDTH-1:0] len_m1;
    logic [CHK_WIDTH-1:0] addr_x;
    logic [CHK_WIDTH-1:0] stride_x;
    logic [CHK_WIDTH-1:0] last_x;
    logic [CHK_WIDTH-1:0] end_x;

    assign len_m1   = req.len - LEN_WIDTH'(1);
    assign addr_x   = CHK_WIDTH'(req.addr);
    assign stride_x = CHK_WIDTH'(req.stride);
    assign last_x   = CHK_WIDTH'(len_m1);
    // Only meaningful once the length has passed; the priority chain below
    // guarantees that.
    assign end_x    = addr_x + stride_x * last_x;

    always_comb begin
        err = ERR_NONE;
        if (req.len == '0 || req.len > LEN_WIDTH'(BURST_LEN)) begin
            err = ERR_LEN;
        end else if (stride_x > MAX_C) begin
            err = ERR_STRIDE;
        end else if (end_x > MAX_C) begin
            err = ERR_RANGE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/burst_initiator.sv
`default_nettype none
// ============================================================================
// Module      : burst_initiator
// Description : Accepts one burst request over valid/ready, validates it,
//               then drives burst_en/addr_in/stride into the address
//               modifier while publishing the expected per-beat address.
//               Sequence: IDLE -> SETUP -> BURST (len beats) -> GAP -> IDLE.
// Ports       : clk, rstn (async active-low)
//               req_valid/req_ready          request handshake
//               req_addr/req_stride/req_len  request fields
//               burst_en/addr_in/stride      to address modifier
//               beat_valid/beat_idx/beat_addr per-beat expectation
//               done  1-cycle pulse at burst completion
//               err   1-cycle pulse on rejection, err_code held to next accept
// Revision    : 1.0 - initial release
// ============================================================================
module burst_initiator
    import burst_initiator_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRIDE_LEN-1:0] req_stride,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  burst_en,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [STRIDE_LEN-1:0] stride,
    output logic                  beat_valid,
    output logic [IDX_WIDTH-1:0]  beat_idx,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    bt_state_e            state;
    bt_err_e              chk_err;
    bt_err_e              err_q;
    burst_req_t           req;
    logic [IDX_WIDTH-1:0] last_idx;
    logic [GAP_W-1:0]     gap_cnt;

    assign req.addr   = req_addr;
    assign req.stride = req_stride;
    assign req.len    = req_len;

    burst_range_check u_range_check (
        .req (req),
        .err (chk_err)
    );

    assign err_code   = err_q;
    // burst_en is itself a register, so this stays a registered output.
    assign beat_valid = burst_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            burst_en  <= 1'b0;
            addr_in   <= '0;
            stride    <= '0;
            beat_idx  <= '0;
            beat_addr <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_q     <= ERR_NONE;
            last_idx  <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                        err_q     <= chk_err;
                        err       <= (chk_err != ERR_NONE);
                        // A rejected request leaves the modifier inputs alone.
                        if (chk_err == ERR_NONE) begin
                            addr_in  <= req_addr;
                            stride   <= req_stride;
                            last_idx <= IDX_WIDTH'(req_len - LEN_WIDTH'(1));
                        end
                    end
                end
                SETUP: begin
                    // burst_en stays low this cycle so the modifier loads addr_in.
                    if (err_q != ERR_NONE) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state     <= BURST;
                        burst_en  <= 1'b1;
                        beat_idx  <= '0;
                        beat_addr <= addr_in;
                    end
                end
                BURST: begin
                    if (beat_idx == last_idx) begin
                        state     <= GAP;
                        burst_en  <= 1'b0;
                        beat_idx  <= '0;
                        beat_addr <= '0;
                        done      <= 1'b1;
                        gap_cnt   <= '0;
                    end else begin
                        beat_idx  <= beat_idx + IDX_WIDTH'(1);
                        beat_addr <= beat_addr + ADDR_WIDTH'(stride);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    burst_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_initiator
// Description : Directed self-checking bench for burst_initiator, with a
//               small behavioural address modifier attached to its outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_initiator;
    import burst_initiator_pkg::*;

    logic                  clk;
    logic                  rstn;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [STRIDE_LEN-1:0] req_stride;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  burst_en;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [STRIDE_LEN-1:0] stride;
    logic                  beat_valid;
    logic [IDX_WIDTH-1:0]  beat_idx;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;

    int vectors;
    int miscompares;

    // Address modifier: loads addr_in while burst_en is low, steps by stride
    // on every burst_en cycle.
    logic [ADDR_WIDTH-1:0] addr_modified;

    burst_initiator #(.GAP_CYCLES(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_stride (req_stride),
        .req_len    (req_len),
        .burst_en   (burst_en),
        .addr_in    (addr_in),
        .stride     (stride),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .beat_addr  (beat_addr),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            addr_modified <= '0;
        else if (!burst_en)
            addr_modified <= addr_in;
        else
            addr_modified <= addr_modified + ADDR_WIDTH'(stride);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int s, input int l);
        req_valid  = v;
        req_addr   = ADDR_WIDTH'(a);
        req_stride = STRIDE_LEN'(s);
        req_len    = LEN_WIDTH'(l);
    endtask

    int cfg_addr [2];
    int cfg_strd [2];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        drive(1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // ---- reset state
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_burst_en",   32'(burst_en),   32'd0);
        chk("rst_beat_valid", 32'(beat_valid), 32'd0);
        chk("rst_addr_in",    32'(addr_in),    32'd0);
        chk("rst_stride",     32'(stride),     32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_err",        32'(err),        32'd0);
        chk("rst_err_code",   32'(err_code),   32'd0);
        rstn = 1'b1;
        tick();

        // ---- basic burst: 0x10 stride 2 len 4
        drive(1'b1, 'h10, 2, 4);
        tick();                                   // T1
        drive(1'b0, 0, 0, 0);
        chk("b1_t1_ready",    32'(req_ready), 32'd0);
        chk("b1_t1_burst_en", 32'(burst_en),  32'd0);
        chk("b1_t1_addr_in",  32'(addr_in),   32'h10);
        chk("b1_t1_stride",   32'(stride),    32'd2);
        chk("b1_t1_err",      32'(err),       32'd0);
        tick();                                   // T2
        for (int k = 0; k < 4; k++) begin
            chk("b1_burst_en",  32'(burst_en),  32'd1);
            chk("b1_beat_idx",  32'(beat_idx),  32'(k));
            chk("b1_beat_addr", 32'(beat_addr), 32'('h10 + 2 * k));
            chk("b1_addr_hold", 32'(addr_in),   32'h10);
            chk("b1_done_low",  32'(done),      32'd0);
            tick();
        end                                       // T6
        chk("b1_t6_done",      32'(done),      32'd1);
        chk("b1_t6_burst_en",  32'(burst_en),  32'd0);
        chk("b1_t6_beat_addr", 32'(beat_addr), 32'd0);
        chk("b1_t6_ready",     32'(req_ready), 32'd0);
        tick();                                   // T7
        chk("b1_t7_done",  32'(done),      32'd0);
        chk("b1_t7_ready", 32'(req_ready), 32'd0);
        tick();                                   // T8
        chk("b1_t8_ready", 32'(req_ready), 32'd1);

        // ---- bad length: 0 then 9
        drive(1'b1, 'h10, 2, 0);
        tick();
        drive(1'b1, 'h10, 2, 9);
        chk("len0_err",      32'(err),       32'd1);
        chk("len0_code",     32'(err_code),  32'd1);
        chk("len0_burst_en", 32'(burst_en),  32'd0);
        chk("len0_ready_t1", 32'(req_ready), 32'd0);
        tick();
        chk("len0_ready_t2", 32'(req_ready), 32'd1);
        chk("len0_err_t2",   32'(err),       32'd0);
        chk("len0_code_t2",  32'(err_code),  32'd1);
        tick();
        drive(1'b0, 0, 0, 0);
        chk("len9_err",      32'(err),      32'd1);
        chk("len9_code",     32'(err_code), 32'd1);
        chk("len9_burst_en", 32'(burst_en), 32'd0);
        tick();
        chk("len9_ready", 32'(req_ready), 32'd1);
        chk("len9_nobe",  32'(burst_en),  32'd0);

        // ---- end address range boundary
        drive(1'b1, 'hF8, 4, 3);
        tick();
        drive(1'b0, 0, 0, 0);
        chk("rng_err",  32'(err),      32'd1);
        chk("rng_code", 32'(err_code), 32'd3);
        tick();
        chk("rng_ready", 32'(req_ready), 32'd1);
        drive(1'b1, 'hF7, 4, 3);
        tick();
        drive(1'b0, 0, 0, 0);
        chk("edge_err",     32'(err),      32'd0);
        chk("edge_code",    32'(err_code), 32'd0);
        chk("edge_addr_in", 32'(addr_in),  32'hF7);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("edge_beat_addr", 32'(beat_addr), 32'('hF7 + 4 * k));
            tick();
        end
        chk("edge_done", 32'(done), 32'd1);
        tick();
        tick();
        chk("edge_ready", 32'(req_ready), 32'd1);

        // ---- req_valid held across two requests
        drive(1'b1, 'h40, 3, 4);
        tick();                                   // T1
        drive(1'b1, 'h80, 1, 2);
        repeat (6) tick();                        // T7
        chk("b2b_t7_ready", 32'(req_ready), 32'd0);
        chk("b2b_t7_be",    32'(burst_en),  32'd0);
        tick();                                   // T8
        chk("b2b_t8_ready", 32'(req_ready), 32'd1);
        chk("b2b_t8_be",    32'(burst_en),  32'd0);
        tick();                                   // T9
        drive(1'b0, 0, 0, 0);
        chk("b2b_t9_ready", 32'(req_ready), 32'd0);
        chk("b2b_t9_addr",  32'(addr_in),   32'h80);
        chk("b2b_t9_be",    32'(burst_en),  32'd0);
        tick();                                   // T10
        chk("b2b_t10_be",   32'(burst_en),  32'd1);
        chk("b2b_t10_addr", 32'(beat_addr), 32'h80);
        tick();
        chk("b2b_t11_addr", 32'(beat_addr), 32'h81);
        tick();
        chk("b2b_done", 32'(done), 32'd1);
        tick();
        tick();
        chk("b2b_ready", 32'(req_ready), 32'd1);

        // ---- reset in the middle of a burst
        drive(1'b1, 'h30, 1, 6);
        tick();                                   // T1
        drive(1'b0, 0, 0, 0);
        tick();                                   // T2
        tick();                                   // T3
        chk("mrst_pre_be", 32'(burst_en), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mrst_be",    32'(burst_en),   32'd0);
        chk("mrst_bv",    32'(beat_valid), 32'd0);
        chk("mrst_ready", 32'(req_ready),  32'd1);
        @(posedge clk);
        #1;
        chk("mrst_done", 32'(done), 32'd0);
        rstn = 1'b1;
        tick();
        chk("mrst_done_after", 32'(done), 32'd0);
        drive(1'b1, 'h05, 1, 1);
        tick();
        drive(1'b0, 0, 0, 0);
        tick();
        chk("post_be",   32'(burst_en),  32'd1);
        chk("post_addr", 32'(beat_addr), 32'h05);
        tick();
        chk("post_done", 32'(done), 32'd1);
        tick();
        tick();

        // ---- full-length bursts against the address modifier
        cfg_addr[0] = 'h55; cfg_strd[0] = 0;
        cfg_addr[1] = 'h00; cfg_strd[1] = 15;
        for (int c = 0; c < 2; c++) begin
            chk("mod_ready", 32'(req_ready), 32'd1);
            drive(1'b1, cfg_addr[c], cfg_strd[c], 8);
            tick();
            drive(1'b0, 0, 0, 0);
            chk("mod_code", 32'(err_code), 32'd0);
            tick();
            for (int k = 0; k < 8; k++) begin
                chk("mod_beat_idx",  32'(beat_idx),  32'(k));
                chk("mod_beat_addr", 32'(beat_addr), 32'(cfg_addr[c] + cfg_strd[c] * k));
                chk("mod_match",     32'(beat_addr), 32'(addr_modified));
                tick();
            end
            chk("mod_done", 32'(done), 32'd1);
            tick();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
